decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage of the RV32I 5-stage core. Sits between the IF/ID register and the execute stage, wrapped around the 32-entry register file.
- Splits the fetched instruction into fields and drives the register-file read addresses.
- Bypasses same-cycle write-back data, generates immediates and control, detects load-use hazards, and owns the ID/EX pipeline register with a valid/ready handshake, stall and flush.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- RESET_PC, 32'h0000_0000, value loaded into pc_e and pc_plus4_e on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- instr_d  in  32  instruction word.
- pc_d  in  XLEN  instruction PC.
- pc_plus4_d  in  XLEN  pc_d+4.
- rf_a1  out  REG_AW  register-file read address 1 (instr_d[19:15]).
- rf_a2  out  REG_AW  register-file read address 2 (instr_d[24:20]).
- rf_rd1  in  XLEN  register-file read data 1.
- rf_rd2  in  XLEN  register-file read data 2.
- wb_we  in  1  write-back stage writes this cycle.
- wb_rd  in  REG_AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- flush  in  1  branch/jump redirect from execute; kill the ID instruction.
- ex_ready  in  1  execute accepts the ID/EX contents.
- ex_valid  out  1  ID/EX holds a valid instruction.
- rd1_e, rd2_e  out  XLEN  operand values.
- imm_e  out  XLEN  sign-extended immediate.
- rs1_e, rs2_e, rd_e  out  REG_AW  register indices (for the forwarding unit).
- pc_e, pc_plus4_e  out  XLEN  registered PCs.
- reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e  out  1 each  control.
- result_src_e  out  2  00 ALU, 01 memory, 10 pc+4.
- alu_ctrl_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_e  out  1  unsupported opcode.

Behaviour:
- Reset (rst=0, asynchronous):
  - ex_valid and all control outputs are 0.
  - Data and index outputs are 0; pc_e and pc_plus4_e are RESET_PC.
- Decoded opcodes:
  - lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
  - Anything else sets illegal=1 with reg_write=mem_write=branch=jump=0.
- Immediates:
  - I {20{i[31]},i[31:20]}
  - S {20{i[31]},i[31:25],i[11:7]}
  - B {19{i[31]},i[31],i[7],i[30:25],i[11:8],1'b0}
  - J {11{i[31]},i[31],i[19:12],i[20],i[30:21],1'b0}
- alu_ctrl:
  - lw, sw → add; beq → sub.
  - R/I-ALU: funct3 000 gives add, or sub when R-type and funct7[5]=1. funct3 010→slt, 110→or, 111→and.
  - Other funct3 → illegal.
- Bypass: if wb_we && wb_rd!=0 && wb_rd==rf_a1, then operand1 = wb_data, else rf_rd1. Same rule for operand 2. Fully combinational; covers the register file's write-at-edge/read-combinational gap.
- Load-use hazard:
  - hz = ex_valid && result_src_e==01 && rd_e!=0 && (rd_e==rs1_d || (uses_rs2 && rd_e==rs2_d)).
  - uses_rs2 = R-type, sw or beq.
- Handshake:
  - advance = ex_ready || !ex_valid.
  - in_ready = advance && !hz && !flush.
- ID/EX update at each rising edge, in priority order:
  - (1) flush: ex_valid←0 and all control←0, regardless of ex_ready.
  - (2) !advance: hold every output.
  - (3) hz: insert a bubble (ex_valid←0, control←0) and do not consume instr_d.
  - (4) in_valid: load all fields, ex_valid←1.
  - (5) otherwise: ex_valid←0.
- Stage latency is 1 cycle. The bypass has zero added latency.
- x0: rd=0 forces reg_write_e=0.
- illegal_e is registered alongside ex_valid=1 so execute can trap. It carries no other side effect.
- Reset asserted mid-operation discards ID/EX immediately. No state survives.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALU_ADD/SUB/AND/OR/SLT codes
  - RES_ALU/RES_MEM/RES_PC4 codes
  - imm_src enum
- One sub-module, decode_ctrl: purely combinational opcode/funct → control, imm_src and illegal. The top level holds the immediate generator, bypass, hazard logic and ID/EX register.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → ex_valid=0, reg_write_e=0, pc_e=0. After release, a valid instr is registered 1 cycle later.
- Decode: add x3,x1,x2 (0x002081B3) with rf_rd1=5, rf_rd2=7 → next cycle rd1_e=5, rd2_e=7, rd_e=3, alu_ctrl_e=000, reg_write_e=1. Also lw x5,-4(x2) (0xFFC12283) → imm_e=0xFFFFFFFC, result_src_e=01.
- Bypass: wb_we=1, wb_rd=1, wb_data=0xDEAD_BEEF, rf_rd1=0x11 while decoding add x3,x1,x2 → rd1_e=0xDEADBEEF. Repeat with wb_rd=0 → rd1_e=0x11.
- Load-use: lw x5 in EX, ID holds add x6,x5,x1 → in_ready=0 for 1 cycle, bubble (ex_valid=0), then the add is registered with ex_valid=1.
- Back-pressure and flush: ex_ready=0 for 4 cycles → all outputs hold, in_ready=0. Then flush=1 with ex_ready=0 → ex_valid=0 next cycle.
- Illegal: instr 0x0000007F → ex_valid=1, illegal_e=1, reg_write_e=0, mem_write_e=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes,
// result-source selects and the immediate-format enum.
package rv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational main/ALU decoder: opcode and funct fields in,
// control bundle, immediate format and illegal flag out.
module decode_ctrl
  import rv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       reg_write,
  output logic       mem_write,
  output logic       alu_src,
  output logic       branch,
  output logic       jump,
  output logic [1:0] result_src,
  output logic [2:0] alu_ctrl,
  output imm_src_t   imm_src,
  output logic       uses_rs2,
  output logic       illegal
);

  // Decode opcode/funct into control; any unsupported encoding zeroes all control
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    result_src = RES_ALU;
    alu_ctrl   = ALU_ADD;
    imm_src    = IMM_I;
    uses_rs2   = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
        uses_rs2  = 1'b1;
      end
      OP_R, OP_I: begin
        reg_write = 1'b1;
        alu_src   = (op == OP_I);
        uses_rs2  = (op == OP_R);
        case (funct3)
          3'b000:  alu_ctrl = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      OP_BEQ: begin
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        imm_src  = IMM_B;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      result_src = RES_ALU;
      alu_ctrl   = ALU_ADD;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: field split, write-back bypass,
// immediate generation, load-use hazard detection and the ID/EX register.
module decode_stage
  import rv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic [1:0]        result_src_e,
  output logic [2:0]        alu_ctrl_e,
  output logic              illegal_e
);

  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]   op1_d, op2_d, imm_d;
  logic              reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d;
  logic [1:0]        result_src_d;
  logic [2:0]        alu_ctrl_d;
  imm_src_t          imm_src_d;
  logic              uses_rs2_d, illegal_d;
  logic              hz, advance;

  // Sign-extend the immediate of the selected instruction format
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i, input imm_src_t s);
    case (s)
      IMM_S:   imm_gen = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   imm_gen = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = {{(XLEN-12){i[31]}}, i[31:20]};
    endcase
  endfunction

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];
  assign rd_d  = instr_d[11:7];
  assign rf_a1 = rs1_d;
  assign rf_a2 = rs2_d;

  decode_ctrl u_ctrl (
    .op         (instr_d[6:0]),
    .funct3     (instr_d[14:12]),
    .funct7_5   (instr_d[30]),
    .reg_write  (reg_write_d),
    .mem_write  (mem_write_d),
    .alu_src    (alu_src_d),
    .branch     (branch_d),
    .jump       (jump_d),
    .result_src (result_src_d),
    .alu_ctrl   (alu_ctrl_d),
    .imm_src    (imm_src_d),
    .uses_rs2   (uses_rs2_d),
    .illegal    (illegal_d)
  );

  assign imm_d = imm_gen(instr_d, imm_src_d);

  // Same-cycle write-back bypass: the register file only updates at the edge
  assign op1_d = (wb_we && wb_rd != '0 && wb_rd == rs1_d) ? wb_data : rf_rd1;
  assign op2_d = (wb_we && wb_rd != '0 && wb_rd == rs2_d) ? wb_data : rf_rd2;

  // A load in EX whose destination feeds this instruction must stall one cycle
  assign hz = ex_valid && result_src_e == RES_MEM && rd_e != '0 &&
              (rd_e == rs1_d || (uses_rs2_d && rd_e == rs2_d));

  assign advance  = ex_ready || !ex_valid;
  assign in_ready = advance && !hz && !flush;

  // ID/EX register: flush > hold > bubble > load > drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      result_src_e <= RES_ALU;
      alu_ctrl_e   <= ALU_ADD;
      illegal_e    <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      pc_e         <= XLEN'(RESET_PC);
      pc_plus4_e   <= XLEN'(RESET_PC);
    end else if (flush || (advance && hz)) begin
      ex_valid     <= 1'b0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      result_src_e <= RES_ALU;
      alu_ctrl_e   <= ALU_ADD;
      illegal_e    <= 1'b0;
    end else if (!advance) begin
      ex_valid <= ex_valid;
    end else if (in_valid) begin
      ex_valid     <= 1'b1;
      reg_write_e  <= reg_write_d && rd_d != '0;
      mem_write_e  <= mem_write_d;
      alu_src_e    <= alu_src_d;
      branch_e     <= branch_d;
      jump_e       <= jump_d;
      result_src_e <= result_src_d;
      alu_ctrl_e   <= alu_ctrl_d;
      illegal_e    <= illegal_d;
      rd1_e        <= op1_d;
      rd2_e        <= op2_d;
      imm_e        <= imm_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the ID/EX stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] pc_e, pc_plus4_e;
  logic        reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_ctrl_e;
  logic        illegal_e;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LW_X5  = 32'hFFC12283;  // lw  x5,-4(x2)
  localparam logic [31:0] ADD_X6 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};  // add x6,x5,x1

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .branch_e(branch_e), .jump_e(jump_e), .result_src_e(result_src_e),
    .alu_ctrl_e(alu_ctrl_e), .illegal_e(illegal_e)
  );

  // Reference model state of the ID/EX register
  typedef struct packed {
    logic        v;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, as, br, jp;
    logic [1:0]  rs;
    logic [2:0]  ac;
    logic        ill;
    logic        imm_known;
    logic        uses2;
  } st_t;

  st_t m, nx;

  // Architectural meaning of one instruction word
  function automatic st_t ref_decode(input logic [31:0] i);
    st_t d;
    logic writes, legal;
    d = '0;
    writes = 1'b0;
    legal  = 1'b1;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    d.imm_known = 1'b1;
    if (i[6:0] == 7'b0000011) begin            // lw
      writes = 1; d.as = 1; d.rs = 2'b01;
      d.imm = {{20{i[31]}}, i[31:20]};
    end else if (i[6:0] == 7'b0100011) begin   // sw
      d.mw = 1; d.as = 1; d.uses2 = 1;
      d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
    end else if (i[6:0] == 7'b0110011 || i[6:0] == 7'b0010011) begin
      writes = 1;
      d.as = (i[6:0] == 7'b0010011);
      d.uses2 = !d.as;
      if (d.as) d.imm = {{20{i[31]}}, i[31:20]};
      else d.imm_known = 1'b0;
      if (i[14:12] == 3'd0) d.ac = (!d.as && i[30]) ? 3'b001 : 3'b000;
      else if (i[14:12] == 3'd2) d.ac = 3'b101;
      else if (i[14:12] == 3'd6) d.ac = 3'b011;
      else if (i[14:12] == 3'd7) d.ac = 3'b010;
      else legal = 1'b0;
    end else if (i[6:0] == 7'b1100011) begin   // beq
      d.br = 1; d.ac = 3'b001; d.uses2 = 1;
      d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    end else if (i[6:0] == 7'b1101111) begin   // jal
      d.jp = 1; writes = 1; d.rs = 2'b10;
      d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      writes = 0; d.mw = 0; d.as = 0; d.br = 0; d.jp = 0; d.rs = 0; d.ac = 0;
      d.ill = 1; d.imm_known = 1'b0;
    end
    d.rw = writes && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic st_t reset_state();
    st_t r;
    r = '0;
    r.imm_known = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; instr_d = 32'h13; pc_d = 0; pc_plus4_d = 4;
    rf_rd1 = 0; rf_rd2 = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; in_valid = 1; instr_d = ADD_X3; pc_d = 32'h100; pc_plus4_d = 32'h104;
    repeat (3) tick();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    n_checks++;
    if (reg_write_e !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got %0b want 0", reg_write_e); end
    n_checks++;
    if (pc_e !== 32'h0 || pc_plus4_e !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc got %h/%h want 0/0", pc_e, pc_plus4_e);
    end
    n_checks++;
    if ({rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h want zeros", rd1_e, rd2_e, imm_e);
    end
    rst = 1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || pc_e !== 32'h100) begin
      n_fail++; $display("FAIL reset_first_load got v=%0b pc=%h want v=1 pc=100", ex_valid, pc_e);
    end
  endtask

  task automatic test_decode();
    in_valid = 1; instr_d = ADD_X3; rf_rd1 = 5; rf_rd2 = 7; pc_d = 32'h104; pc_plus4_d = 32'h108;
    tick();
    n_checks++;
    if (rd1_e !== 32'd5 || rd2_e !== 32'd7) begin
      n_fail++; $display("FAIL decode_add_ops got %0d,%0d want 5,7", rd1_e, rd2_e);
    end
    n_checks++;
    if (rd_e !== 5'd3 || alu_ctrl_e !== 3'b000 || reg_write_e !== 1'b1 || result_src_e !== 2'b00) begin
      n_fail++; $display("FAIL decode_add_ctrl got rd=%0d alu=%b rw=%b rs=%b want 3 000 1 00",
                         rd_e, alu_ctrl_e, reg_write_e, result_src_e);
    end
    instr_d = LW_X5; pc_d = 32'h108; pc_plus4_d = 32'h10C;
    tick();
    n_checks++;
    if (imm_e !== 32'hFFFF_FFFC || result_src_e !== 2'b01 || rd_e !== 5'd5) begin
      n_fail++; $display("FAIL decode_lw got imm=%h rs=%b rd=%0d want fffffffc 01 5", imm_e, result_src_e, rd_e);
    end
  endtask

  task automatic test_bypass();
    in_valid = 1; instr_d = ADD_X3; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    wb_we = 1; wb_rd = 1; wb_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %0b want 1", in_ready); end
    tick();
    n_checks++;
    if (rd1_e !== 32'hDEAD_BEEF || rd2_e !== 32'h22) begin
      n_fail++; $display("FAIL bypass_hit got %h,%h want deadbeef,22", rd1_e, rd2_e);
    end
    wb_rd = 0;
    tick();
    n_checks++;
    if (rd1_e !== 32'h11) begin n_fail++; $display("FAIL bypass_x0 got %h want 11", rd1_e); end
    wb_we = 0;
  endtask

  task automatic test_load_use();
    in_valid = 1; instr_d = LW_X5; pc_d = 32'h200;
    tick();
    instr_d = ADD_X6; pc_d = 32'h300; pc_plus4_d = 32'h304; rf_rd1 = 32'h55; rf_rd2 = 32'h66;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall got %0b want 0", in_ready); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || result_src_e !== 2'b00) begin
      n_fail++; $display("FAIL loaduse_bubble got v=%0b rs=%b want 0 00", ex_valid, result_src_e);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_resume got %0b want 1", in_ready); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || rd_e !== 5'd6 || rs1_e !== 5'd5 || pc_e !== 32'h300) begin
      n_fail++; $display("FAIL loaduse_issue got v=%0b rd=%0d rs1=%0d pc=%h want 1 6 5 300",
                         ex_valid, rd_e, rs1_e, pc_e);
    end
  endtask

  task automatic test_backpressure_flush();
    ex_ready = 0; in_valid = 1; instr_d = 32'h00402383; pc_d = 32'h400; pc_plus4_d = 32'h404;
    rf_rd1 = 32'h99; rf_rd2 = 32'h98;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d got %0b want 0", k, in_ready); end
      tick();
      n_checks++;
      if (ex_valid !== 1'b1 || rd_e !== 5'd6 || pc_e !== 32'h300 || rd1_e !== 32'h55 || reg_write_e !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold cyc%0d got v=%0b rd=%0d pc=%h op1=%h want 1 6 300 55", k,
                           ex_valid, rd_e, pc_e, rd1_e);
      end
    end
    flush = 1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || reg_write_e !== 1'b0) begin
      n_fail++; $display("FAIL flush got v=%0b rw=%0b want 0 0", ex_valid, reg_write_e);
    end
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_illegal();
    in_valid = 1; instr_d = 32'h0000_007F;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || illegal_e !== 1'b1 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0) begin
      n_fail++; $display("FAIL illegal got v=%0b ill=%0b rw=%0b mw=%0b want 1 1 0 0",
                         ex_valid, illegal_e, reg_write_e, mem_write_e);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic       hz, adv, exp_ready;
    st_t        d;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    m = reset_state();
    for (int it = 0; it < 500; it++) begin
      in_valid = ($urandom_range(0, 9) < 8);
      instr_d  = $urandom;
      if ($urandom_range(0, 9) < 8) instr_d[6:0] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) begin
        instr_d[19:15] = 5'($urandom_range(0, 7));
        instr_d[24:20] = 5'($urandom_range(0, 7));
        instr_d[11:7]  = 5'($urandom_range(0, 7));
      end
      pc_d       = $urandom;
      pc_plus4_d = pc_d + 32'd4;
      rf_rd1     = $urandom;
      rf_rd2     = $urandom;
      wb_we      = $urandom_range(0, 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      flush      = ($urandom_range(0, 9) == 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      #2;
      d   = ref_decode(instr_d);
      hz  = m.v && m.rs == 2'b01 && m.rd != 0 && (m.rd == d.rs1 || (d.uses2 && m.rd == d.rs2));
      adv = ex_ready || !m.v;
      exp_ready = adv && !hz && !flush;
      n_checks++;
      if (in_ready !== exp_ready || rf_a1 !== d.rs1 || rf_a2 !== d.rs2) begin
        n_fail++; $display("FAIL rnd_comb it%0d got rdy=%0b a1=%0d a2=%0d want %0b %0d %0d", it,
                           in_ready, rf_a1, rf_a2, exp_ready, d.rs1, d.rs2);
      end
      nx = m;
      if (flush || (adv && hz)) begin
        nx.v = 0; nx.rw = 0; nx.mw = 0; nx.as = 0; nx.br = 0; nx.jp = 0; nx.rs = 0; nx.ac = 0; nx.ill = 0;
      end else if (!adv) begin
        nx = m;
      end else if (in_valid) begin
        nx = d;
        nx.v   = 1;
        nx.rd1 = (wb_we && wb_rd != 0 && wb_rd == d.rs1) ? wb_data : rf_rd1;
        nx.rd2 = (wb_we && wb_rd != 0 && wb_rd == d.rs2) ? wb_data : rf_rd2;
        nx.pc  = pc_d;
        nx.pc4 = pc_plus4_d;
        if (!d.imm_known) nx.imm = 'x;
      end else begin
        nx.v = 0;
      end
      m = nx;
      tick();
      n_checks++;
      if ({ex_valid, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, result_src_e, alu_ctrl_e, illegal_e}
          !== {m.v, m.rw, m.mw, m.as, m.br, m.jp, m.rs, m.ac, m.ill}) begin
        n_fail++; $display("FAIL rnd_ctrl it%0d got %b want %b", it,
          {ex_valid, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, result_src_e, alu_ctrl_e, illegal_e},
          {m.v, m.rw, m.mw, m.as, m.br, m.jp, m.rs, m.ac, m.ill});
      end
      n_checks++;
      if ({rd1_e, rd2_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e} !== {m.rd1, m.rd2, m.pc, m.pc4, m.rs1, m.rs2, m.rd}) begin
        n_fail++; $display("FAIL rnd_data it%0d got %h %h %h %h %0d %0d %0d want %h %h %h %h %0d %0d %0d", it,
          rd1_e, rd2_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e, m.rd1, m.rd2, m.pc, m.pc4, m.rs1, m.rs2, m.rd);
      end
      if (m.imm_known) begin
        n_checks++;
        if (imm_e !== m.imm) begin n_fail++; $display("FAIL rnd_imm it%0d got %h want %h", it, imm_e, m.imm); end
      end
      if (it == 250) begin
        rst = 0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || reg_write_e !== 1'b0 || pc_e !== 32'h0 || rd1_e !== 32'h0) begin
          n_fail++; $display("FAIL rnd_async_reset got v=%0b rw=%0b pc=%h op1=%h want 0 0 0 0",
                             ex_valid, reg_write_e, pc_e, rd1_e);
        end
        rst = 1;
        m = reset_state();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle_inputs();
    #2;
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_backpressure_flush();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
